// File: rtl/pending_enc_pkg.sv
// Shared types, defaults and helpers for the pending-request priority encoder.
package pending_enc_pkg;

    typedef enum logic [0:0] {IDLE, VALID} state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r++;
        end
        return r;
    endfunction

    localparam int unsigned DefN    = 32;
    localparam int unsigned DefW    = clog2(DefN);
    localparam int unsigned DefCntW = 8;

endpackage

// File: rtl/priority_select.sv
// Combinational find-first-set over an N-bit vector, searching upward from a
// rotate base and wrapping at N.
module priority_select #(
    parameter int unsigned N = 32,
    parameter int unsigned W = 5
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] base,
    output logic         found,
    output logic [W-1:0] index,
    output logic [N-1:0] onehot
);

    int unsigned pos;

    always_comb begin
        found  = 1'b0;
        index  = '0;
        onehot = '0;
        pos    = 0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = 32'(base) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!found && vec[W'(pos)]) begin
                found          = 1'b1;
                index          = W'(pos);
                onehot[W'(pos)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pending_priority_encoder.sv
// Latches request pulses into a pending vector and grants them one at a time
// under valid/ready. Optional ROUND_ROBIN_EN rotates priority past the last grant.
module pending_priority_encoder
    import pending_enc_pkg::*;
#(
    parameter int unsigned N     = DefN,
    parameter int unsigned W     = clog2(N),
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [N-1:0]     req_in,
    input  logic [N-1:0]     mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_index,
    output logic [N-1:0]     out_onehot,
    output logic [N-1:0]     pending,
    output logic [CNT_W-1:0] overflow_cnt
);

    state_e             state_q, state_d;
    logic [N-1:0]       pending_q, pending_d;
    logic [W-1:0]       index_q, index_d;
    logic [N-1:0]       onehot_q, onehot_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic [N-1:0]       held;
    logic [N-1:0]       accept_clr;
    logic [N-1:0]       cand;
    logic               collide;
    logic [W-1:0]       base;
    logic               sel_found;
    logic [W-1:0]       sel_index;
    logic [N-1:0]       sel_onehot;

`ifdef ROUND_ROBIN_EN
    logic [W-1:0] last_q, last_d, base_src;

    // On acceptance the next search starts just past the grant being retired.
    always_comb begin
        base_src = accept ? index_q : last_q;
        base     = (base_src == W'(N - 1)) ? '0 : base_src + W'(1);
        last_d   = accept ? index_q : last_q;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            last_q <= W'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign base = '0;
`endif

    priority_select #(
        .N (N),
        .W (W)
    ) u_select (
        .vec    (cand),
        .base   (base),
        .found  (sel_found),
        .index  (sel_index),
        .onehot (sel_onehot)
    );

    always_comb begin
        accept     = (state_q == VALID) && out_ready;
        held       = (state_q == VALID) ? onehot_q : '0;
        accept_clr = accept ? onehot_q : '0;
        cand       = pending_q & ~mask & ~held;
        pending_d  = (pending_q & ~accept_clr) | req_in;
        collide    = |(req_in & pending_q & ~accept_clr);
        cnt_d      = (collide && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        onehot_d = onehot_q;
        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    index_d  = sel_index;
                    onehot_d = sel_onehot;
                    state_d  = VALID;
                end
            end
            VALID: begin
                // Held grant never retracts; only acceptance moves it on.
                if (accept) begin
                    if (sel_found) begin
                        index_d  = sel_index;
                        onehot_d = sel_onehot;
                    end else begin
                        onehot_d = '0;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                onehot_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= IDLE;
            pending_q <= '0;
            index_q   <= '0;
            onehot_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            index_q   <= index_d;
            onehot_q  <= onehot_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid    = (state_q == VALID);
    assign out_index    = index_q;
    assign out_onehot   = onehot_q;
    assign pending      = pending_q;
    assign overflow_cnt = cnt_q;

endmodule
